pipe_decode_rf: RTL and testbench

Parametrised decode stage for the pipelined Y86-64 core. It contains the following pieces:
- an NREGS-entry register file with two synchronous write ports (W_dstE, W_dstM);
- source/destination register selection from the D-stage icode;
- a five-source operand forwarding network;
- the E pipeline register, with stall and bubble control.

It sits between the fetch/D register and the execute stage. Compared with the earlier decode block, it adds reset, register-file width and depth parameters, E-register stall, and dst-driven write enables.

---
 rtl/y86_pkg.sv | 23 ++
 rtl/y86_regfile.sv | 36 +++
 rtl/pipe_decode_rf.sv | 120 ++++++++++++
 tb/tb_pipe_decode_rf.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 icodes, status encodings, register indices and E-register bubble values.
package y86_pkg;
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;
  localparam logic [3:0] S_AOK = 4'b1000;
  localparam logic [3:0] S_HLT = 4'b0100;
  localparam logic [3:0] S_ADR = 4'b0010;
  localparam logic [3:0] S_INS = 4'b0001;
  localparam int RNONE_DEF = 15;
  localparam int RSP_DEF   = 4;
  localparam logic [3:0] BUB_STAT  = S_AOK;
  localparam logic [3:0] BUB_ICODE = I_NOP;
  localparam logic [3:0] BUB_IFUN  = 4'h0;
endpackage

// File: rtl/y86_regfile.sv
// y86_regfile: NREGS x DATA_W register file, two async reads, two sync writes (M port wins on collision).
module y86_regfile
  import y86_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NREGS = 15,
  parameter int RA_W = 4,
  parameter logic [RA_W-1:0] RNONE = RA_W'(RNONE_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RA_W-1:0]   src_a,
  input  logic [RA_W-1:0]   src_b,
  input  logic [RA_W-1:0]   dst_e,
  input  logic [DATA_W-1:0] val_e,
  input  logic [RA_W-1:0]   dst_m,
  input  logic [DATA_W-1:0] val_m,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b
);
  logic [DATA_W-1:0] regs [NREGS];
  logic we_e, we_m;
  assign we_e = dst_e != RNONE && int'(dst_e) < NREGS;
  assign we_m = dst_m != RNONE && int'(dst_m) < NREGS;
  assign rd_a = (src_a != RNONE && int'(src_a) < NREGS) ? regs[src_a] : '0;
  assign rd_b = (src_b != RNONE && int'(src_b) < NREGS) ? regs[src_b] : '0;
  // M write is issued last so it overrides E when both target one register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (we_e) regs[dst_e] <= val_e;
      if (we_m) regs[dst_m] <= val_m;
    end
  end
endmodule

// File: rtl/pipe_decode_rf.sv
// pipe_decode_rf: Y86-64 decode stage with regfile, forwarding and E register.
// Optional load-use detect output enabled by defining DECODE_LOADUSE_DETECT_EN.
module pipe_decode_rf
  import y86_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NREGS = 15,
  parameter int RA_W = 4,
  parameter logic [RA_W-1:0] RNONE = RA_W'(RNONE_DEF),
  parameter logic [RA_W-1:0] RSP = RA_W'(RSP_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        D_stat,
  input  logic [3:0]        D_icode,
  input  logic [3:0]        D_ifun,
  input  logic [RA_W-1:0]   D_rA,
  input  logic [RA_W-1:0]   D_rB,
  input  logic [DATA_W-1:0] D_valC,
  input  logic [DATA_W-1:0] D_valP,
  input  logic              E_stall,
  input  logic              E_bubble,
  input  logic [RA_W-1:0]   e_dstE,
  input  logic [DATA_W-1:0] e_valE,
  input  logic [RA_W-1:0]   M_dstE,
  input  logic [RA_W-1:0]   M_dstM,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [RA_W-1:0]   W_dstE,
  input  logic [RA_W-1:0]   W_dstM,
  input  logic [DATA_W-1:0] W_valE,
  input  logic [DATA_W-1:0] W_valM,
  input  logic [3:0]        M_icode,
  input  logic [RA_W-1:0]   M_dstM_ld,
  output logic [RA_W-1:0]   d_srcA,
  output logic [RA_W-1:0]   d_srcB,
  output logic [3:0]        E_stat,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [DATA_W-1:0] E_valC,
  output logic [DATA_W-1:0] E_valA,
  output logic [DATA_W-1:0] E_valB,
  output logic [RA_W-1:0]   E_dstE,
  output logic [RA_W-1:0]   E_dstM,
  output logic [RA_W-1:0]   E_srcA,
  output logic [RA_W-1:0]   E_srcB,
  output logic              ld_use_hazard
);
  logic [RA_W-1:0] src_a, src_b, dst_e, dst_m;
  logic [DATA_W-1:0] rd_a, rd_b, val_a, val_b;
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (D_icode)
      I_CMOV:  begin src_a = D_rA; dst_e = D_rB; end
      I_IRMOV: dst_e = D_rB;
      I_RMMOV: begin src_a = D_rA; src_b = D_rB; end
      I_MRMOV: begin src_b = D_rB; dst_m = D_rA; end
      I_OPQ:   begin src_a = D_rA; src_b = D_rB; dst_e = D_rB; end
      I_CALL:  begin src_b = RSP; dst_e = RSP; end
      I_RET:   begin src_a = RSP; src_b = RSP; dst_e = RSP; end
      I_PUSH:  begin src_a = D_rA; src_b = RSP; dst_e = RSP; end
      I_POP:   begin src_a = RSP; src_b = RSP; dst_e = RSP; dst_m = D_rA; end
      default: ;
    endcase
  end
  assign d_srcA = src_a;
  assign d_srcB = src_b;
  y86_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .RA_W(RA_W), .RNONE(RNONE)) u_rf (
    .clk(clk), .rst(rst), .src_a(src_a), .src_b(src_b),
    .dst_e(W_dstE), .val_e(W_valE), .dst_m(W_dstM), .val_m(W_valM),
    .rd_a(rd_a), .rd_b(rd_b)
  );
  // A RNONE source never matches: any dst equal to it is itself RNONE
  function automatic logic [DATA_W-1:0] fwd(input logic [RA_W-1:0] s, input logic [DATA_W-1:0] rf);
    return (s == RNONE) ? rf :
           (s == e_dstE) ? e_valE :
           (s == M_dstM) ? m_valM :
           (s == W_dstM) ? W_valM :
           (s == M_dstE) ? M_valE :
           (s == W_dstE) ? W_valE : rf;
  endfunction
  assign val_a = (D_icode == I_CALL || D_icode == I_JXX) ? D_valP : fwd(src_a, rd_a);
  assign val_b = fwd(src_b, rd_b);
  always_ff @(posedge clk) begin
    if (rst || E_bubble) begin
      E_stat <= BUB_STAT;
      E_icode <= BUB_ICODE;
      E_ifun <= BUB_IFUN;
      E_valC <= '0;
      E_valA <= '0;
      E_valB <= '0;
      E_dstE <= RNONE;
      E_dstM <= RNONE;
      E_srcA <= RNONE;
      E_srcB <= RNONE;
    end else if (!E_stall) begin
      E_stat <= D_stat;
      E_icode <= D_icode;
      E_ifun <= D_ifun;
      E_valC <= D_valC;
      E_valA <= val_a;
      E_valB <= val_b;
      E_dstE <= dst_e;
      E_dstM <= dst_m;
      E_srcA <= src_a;
      E_srcB <= src_b;
    end
  end
`ifdef DECODE_LOADUSE_DETECT_EN
  assign ld_use_hazard = (E_icode == I_MRMOV || E_icode == I_POP) && E_dstM != RNONE &&
                         (E_dstM == src_a || E_dstM == src_b);
`else
  assign ld_use_hazard = 1'b0;
`endif
  logic unused_ld;
  assign unused_ld = ^{M_icode, M_dstM_ld};
endmodule

// File: tb/tb_pipe_decode_rf.sv
// tb_pipe_decode_rf: directed + random checks of pipe_decode_rf against a table-driven reference model.
module tb_pipe_decode_rf;
  logic clk = 0, rst;
  logic [3:0] D_stat, D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic E_stall, E_bubble;
  logic [3:0] e_dstE, M_dstE, M_dstM, W_dstE, W_dstM, M_icode, M_dstM_ld;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0] d_srcA, d_srcB, E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0] E_valC, E_valA, E_valB;
  logic ld_use_hazard;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  pipe_decode_rf dut (
    .clk(clk), .rst(rst), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP),
    .E_stall(E_stall), .E_bubble(E_bubble), .e_dstE(e_dstE), .e_valE(e_valE),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE), .m_valM(m_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
    .M_icode(M_icode), .M_dstM_ld(M_dstM_ld), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC),
    .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .E_srcA(E_srcA), .E_srcB(E_srcB), .ld_use_hazard(ld_use_hazard)
  );

  typedef struct {
    logic [3:0] stat, icode, ifun, dste, dstm, srca, srcb;
    logic [63:0] valc, vala, valb;
  } e_t;
  localparam e_t BUB = '{stat: 4'b1000, icode: 4'h1, ifun: 4'h0, dste: 4'hF, dstm: 4'hF,
                         srca: 4'hF, srcb: 4'hF, valc: 64'h0, vala: 64'h0, valb: 64'h0};
  logic [63:0] mem [15];
  e_t exp_e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Spec table: per icode, which of rA/rB/%rsp feeds each of srcA, srcB, dstE, dstM
  task automatic model_decode(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                              output logic [3:0] sa, output logic [3:0] sb,
                              output logic [3:0] de, output logic [3:0] dm);
    string t;
    logic [3:0] pick [4];
    case (ic)
      4'h2: t = "A-B-"; 4'h3: t = "--B-"; 4'h4: t = "AB--"; 4'h5: t = "-B-A";
      4'h6: t = "ABB-"; 4'h8: t = "-SS-"; 4'h9: t = "SSS-"; 4'hA: t = "ASS-";
      4'hB: t = "SSSA"; default: t = "----";
    endcase
    for (int k = 0; k < 4; k++)
      pick[k] = (t[k] == "A") ? ra : (t[k] == "B") ? rb : (t[k] == "S") ? 4'd4 : 4'hF;
    sa = pick[0]; sb = pick[1]; de = pick[2]; dm = pick[3];
  endtask

  function automatic logic [63:0] model_read(input logic [3:0] s);
    logic [3:0] d [5];
    logic [63:0] v [5];
    d = '{e_dstE, M_dstM, W_dstM, M_dstE, W_dstE};
    v = '{e_valE, m_valM, W_valM, M_valE, W_valE};
    if (s == 4'hF) return 64'h0;
    for (int k = 0; k < 5; k++) if (d[k] == s) return v[k];
    return mem[s];
  endfunction

  task automatic tick();
    e_t n;
    logic [3:0] sa, sb, de, dm;
    logic exp_h;
    #1;
    model_decode(D_icode, D_rA, D_rB, sa, sb, de, dm);
    chk("d_srcA", 64'(d_srcA), 64'(sa));
    chk("d_srcB", 64'(d_srcB), 64'(sb));
`ifdef DECODE_LOADUSE_DETECT_EN
    exp_h = (exp_e.icode == 4'h5 || exp_e.icode == 4'hB) && exp_e.dstm != 4'hF &&
            (exp_e.dstm == sa || exp_e.dstm == sb);
`else
    exp_h = 1'b0;
`endif
    chk("ld_use_hazard", 64'(ld_use_hazard), 64'(exp_h));
    if (rst || E_bubble) n = BUB;
    else if (E_stall) n = exp_e;
    else begin
      n = '{stat: D_stat, icode: D_icode, ifun: D_ifun, dste: de, dstm: dm, srca: sa, srcb: sb,
            valc: D_valC, vala: (D_icode == 4'h7 || D_icode == 4'h8) ? D_valP : model_read(sa),
            valb: model_read(sb)};
    end
    @(posedge clk);
    #1;
    if (rst) for (int k = 0; k < 15; k++) mem[k] = 64'h0;
    else begin
      if (W_dstE < 4'hF) mem[W_dstE] = W_valE;
      if (W_dstM < 4'hF) mem[W_dstM] = W_valM;
    end
    exp_e = n;
    chk("E_stat", 64'(E_stat), 64'(n.stat));
    chk("E_icode", 64'(E_icode), 64'(n.icode));
    chk("E_ifun", 64'(E_ifun), 64'(n.ifun));
    chk("E_valC", E_valC, n.valc);
    chk("E_valA", E_valA, n.vala);
    chk("E_valB", E_valB, n.valb);
    chk("E_dstE", 64'(E_dstE), 64'(n.dste));
    chk("E_dstM", 64'(E_dstM), 64'(n.dstm));
    chk("E_srcA", 64'(E_srcA), 64'(n.srca));
    chk("E_srcB", 64'(E_srcB), 64'(n.srcb));
  endtask

  task automatic idle();
    rst = 0; E_stall = 0; E_bubble = 0;
    D_stat = 4'b1000; D_icode = 4'h1; D_ifun = 0; D_rA = 4'hF; D_rB = 4'hF;
    D_valC = 0; D_valP = 0;
    e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
    e_valE = 0; M_valE = 0; m_valM = 0; W_valE = 0; W_valM = 0;
    M_icode = 0; M_dstM_ld = 4'hF;
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [3:0] rreg();
    return ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
  endfunction

  initial begin
    exp_e = BUB;
    for (int k = 0; k < 15; k++) mem[k] = 64'h0;
    idle();
    rst = 1; W_dstE = 4'd2; W_valE = 64'h77;
    tick();
    chk("reset_icode", 64'(E_icode), 64'h1);
    chk("reset_stat", 64'(E_stat), 64'h8);
    idle();
    for (int r = 0; r < 15; r++) begin
      D_icode = 4'h6; D_rA = 4'(r); D_rB = 4'(r);
      tick();
      chk("reset_read", E_valA, 64'h0);
    end
    idle(); W_dstE = 4'd3; W_valE = 64'h55;
    tick();
    idle(); D_icode = 4'h6; D_rA = 4'd3; D_rB = 4'd3;
    tick();
    chk("plan_rf_valA", E_valA, 64'h55);
    chk("plan_rf_valB", E_valB, 64'h55);
    chk("plan_rf_dstE", 64'(E_dstE), 64'h3);
    idle(); D_icode = 4'h6; D_rA = 4'd2; D_rB = 4'd0;
    e_dstE = 4'd2; e_valE = 64'hAA; M_dstM = 4'd2; m_valM = 64'hBB;
    tick();
    chk("plan_fwd_e", E_valA, 64'hAA);
    e_dstE = 4'hF;
    tick();
    chk("plan_fwd_m", E_valA, 64'hBB);
    idle(); W_dstE = 4'd4; W_valE = 64'h100; W_dstM = 4'd4; W_valM = 64'h200;
    D_icode = 4'h6; D_rA = 4'd4; D_rB = 4'd5;
    tick();
    chk("plan_w_fwd", E_valA, 64'h200);
    idle(); D_icode = 4'h6; D_rA = 4'd4; D_rB = 4'd4;
    tick();
    chk("plan_w_prio", E_valA, 64'h200);
    idle(); D_icode = 4'h3; D_rB = 4'd9; D_valC = 64'h1234;
    tick();
    E_stall = 1;
    for (int k = 0; k < 3; k++) begin
      D_icode = 4'($urandom_range(0, 15)); D_rA = rreg(); D_rB = rreg(); D_valC = r64();
      tick();
      chk("stall_valC", E_valC, 64'h1234);
    end
    E_bubble = 1;
    tick();
    chk("stall_bubble", 64'(E_icode), 64'h1);
    idle(); D_icode = 4'h5; D_rA = 4'd1; D_rB = 4'd0;
    tick();
    D_icode = 4'h6; D_rA = 4'd1; D_rB = 4'd2;
    tick();
    idle(); D_icode = 4'h6; D_rA = 4'd7; D_rB = 4'd2;
    tick();
    for (int it = 0; it < 400; it++) begin
      rst = ($urandom_range(0, 59) == 0);
      E_bubble = ($urandom_range(0, 9) == 0);
      E_stall = ($urandom_range(0, 7) == 0);
      D_stat = 4'b0001 << $urandom_range(0, 3);
      D_icode = 4'($urandom_range(0, 15)); D_ifun = 4'($urandom_range(0, 15));
      D_rA = rreg(); D_rB = rreg(); D_valC = r64(); D_valP = r64();
      e_dstE = rreg(); M_dstE = rreg(); M_dstM = rreg(); W_dstE = rreg(); W_dstM = rreg();
      e_valE = r64(); M_valE = r64(); m_valM = r64(); W_valE = r64(); W_valM = r64();
      M_icode = 4'($urandom_range(0, 15)); M_dstM_ld = rreg();
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
